// File: rtl/soundweb_decoder.sv
// Soundweb serial-control receiver: frames on STX/ETX, removes ESC stuffing,
// checks the XOR checksum and presents the 13 decoded fields with status strobes.
module soundweb_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] command,
    output logic [7:0] address_0,
    output logic [7:0] address_1,
    output logic [7:0] address_2,
    output logic [7:0] address_3,
    output logic [7:0] address_4,
    output logic [7:0] address_5,
    output logic [7:0] sv_0,
    output logic [7:0] sv_1,
    output logic [7:0] data_0,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic [7:0] data_3,
    output logic       packet_valid,
    output logic       checksum_error,
    output logic       framing_error,
    output logic       ack_received,
    output logic       nak_received
);

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] ESC = 8'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_ESCAPE,
        S_ETX_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  xor_q, xor_d;
    logic [7:0]  buf_q    [0:13];
    logic [7:0]  buf_d    [0:13];
    logic [7:0]  fields_q [0:12];
    logic [7:0]  fields_d [0:12];
    logic        pv_q, pv_d;
    logic        cs_q, cs_d;
    logic        fe_q, fe_d;
    logic        ack_q, ack_d;
    logic        nak_q, nak_d;

    logic        store_en;
    logic [7:0]  store_val;
    logic [7:0]  esc_val;

    function automatic logic is_reserved(input logic [7:0] b);
        return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
    endfunction

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        xor_d     = xor_q;
        buf_d     = buf_q;
        fields_d  = fields_q;
        pv_d      = 1'b0;
        cs_d      = 1'b0;
        fe_d      = 1'b0;
        ack_d     = 1'b0;
        nak_d     = 1'b0;
        store_en  = 1'b0;
        store_val = rx_data;
        esc_val   = rx_data - 8'h80;

        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == STX) begin
                        state_d = S_BODY;
                        count_d = 4'd0;
                        xor_d   = 8'h00;
                    end else if (rx_data == ACK) begin
                        ack_d = 1'b1;
                    end else if (rx_data == NAK) begin
                        nak_d = 1'b1;
                    end
                end
                S_BODY: begin
                    if (rx_data == ESC) begin
                        state_d = S_ESCAPE;
                    end else if (rx_data == STX) begin
                        fe_d    = 1'b1;
                        state_d = S_BODY;
                        count_d = 4'd0;
                        xor_d   = 8'h00;
                    end else if (is_reserved(rx_data)) begin
                        fe_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        store_en = 1'b1;
                    end
                end
                S_ESCAPE: begin
                    // Only reserved values may legally be escaped.
                    if (is_reserved(esc_val)) begin
                        store_en  = 1'b1;
                        store_val = esc_val;
                    end else if (rx_data == STX) begin
                        fe_d    = 1'b1;
                        state_d = S_BODY;
                        count_d = 4'd0;
                        xor_d   = 8'h00;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_ETX_WAIT: begin
                    if (rx_data == ETX) begin
                        state_d = S_IDLE;
                        if (buf_q[13] == xor_q) begin
                            pv_d = 1'b1;
                            for (int i = 0; i < 13; i++) begin
                                fields_d[i] = buf_q[i];
                            end
                        end else begin
                            cs_d = 1'b1;
                        end
                    end else if (rx_data == STX) begin
                        fe_d    = 1'b1;
                        state_d = S_BODY;
                        count_d = 4'd0;
                        xor_d   = 8'h00;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (store_en) begin
            for (int i = 0; i < 14; i++) begin
                if (count_q == 4'(i)) begin
                    buf_d[i] = store_val;
                end
            end
            // Index 13 is the checksum itself and stays out of the running XOR.
            if (count_q != 4'd13) begin
                xor_d = xor_q ^ store_val;
            end
            state_d = (count_q == 4'd13) ? S_ETX_WAIT : S_BODY;
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            xor_q   <= 8'h00;
            pv_q    <= 1'b0;
            cs_q    <= 1'b0;
            fe_q    <= 1'b0;
            ack_q   <= 1'b0;
            nak_q   <= 1'b0;
            for (int i = 0; i < 14; i++) begin
                buf_q[i] <= 8'h00;
            end
            for (int i = 0; i < 13; i++) begin
                fields_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            xor_q    <= xor_d;
            pv_q     <= pv_d;
            cs_q     <= cs_d;
            fe_q     <= fe_d;
            ack_q    <= ack_d;
            nak_q    <= nak_d;
            buf_q    <= buf_d;
            fields_q <= fields_d;
        end
    end

    assign command        = fields_q[0];
    assign address_0      = fields_q[1];
    assign address_1      = fields_q[2];
    assign address_2      = fields_q[3];
    assign address_3      = fields_q[4];
    assign address_4      = fields_q[5];
    assign address_5      = fields_q[6];
    assign sv_0           = fields_q[7];
    assign sv_1           = fields_q[8];
    assign data_0         = fields_q[9];
    assign data_1         = fields_q[10];
    assign data_2         = fields_q[11];
    assign data_3         = fields_q[12];
    assign packet_valid   = pv_q;
    assign checksum_error = cs_q;
    assign framing_error  = fe_q;
    assign ack_received   = ack_q;
    assign nak_received   = nak_q;

endmodule
